serial_sender: RTL and testbench

- UART-style serial transmitter. Accepts a parallel byte on a one-cycle enable strobe and shifts it out as an asynchronous serial frame on a single line: start bit, data LSB first, optional parity, stop bit(s).
- Bit timing comes from an internal divider on the single system clock.
- Sits between a host/control FSM and the external TX pin of the serial transceiver.

---
 rtl/serial_sender.sv | 160 ++++++++++++++++
 tb/tb_serial_sender.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sender.sv
// serial_sender: UART-style transmitter.
// A byte accepted on tx_en is sent as a start bit, then the data bits LSB first,
// then an optional parity bit, then the stop bit(s). Each bit lasts BAUD_DIV
// clock cycles. dout and tx_status are driven straight from flops, so the
// serial line never glitches.
module serial_sender #(
  parameter int BAUD_DIV  = 5,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_en,
  output logic                 dout,
  output logic                 tx_status
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 2);
  localparam logic             HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state_q,  state_d;
  logic [DIV_W-1:0]     div_q,    div_d;
  logic [3:0]           bit_q,    bit_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 par_q,    par_d;
  logic                 dout_q,   dout_d;
  logic                 status_q, status_d;
  logic                 div_last;

  assign div_last  = (div_q == DIV_LAST);
  assign dout      = dout_q;
  assign tx_status = status_q;

  // Next-state logic: the divider runs only while a frame is in progress.
  // Each bit's dout value is loaded on the last cycle of the previous bit,
  // so the line changes exactly on the divider boundary.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    dout_d   = dout_q;
    status_d = status_q;

    if (state_q != S_IDLE) begin
      div_d = div_last ? '0 : div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        dout_d   = 1'b1;
        status_d = 1'b1;
        div_d    = '0;
        bit_d    = '0;
        if (tx_en) begin
          // Accept cycle: the byte is frozen here; later tx_data changes
          // do not reach this frame.
          shift_d  = tx_data;
          par_d    = (^tx_data) ^ ODD_PAR;
          state_d  = S_START;
          dout_d   = 1'b0;
          status_d = 1'b0;
        end
      end

      S_START: begin
        if (div_last) begin
          state_d = S_DATA;
          bit_d   = '0;
          dout_d  = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        end
      end

      S_DATA: begin
        if (div_last) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              state_d = S_PAR;
              dout_d  = par_q;
            end else begin
              state_d = S_STOP;
              dout_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            dout_d  = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end

      S_PAR: begin
        if (div_last) begin
          state_d = S_STOP;
          bit_d   = '0;
          dout_d  = 1'b1;
        end
      end

      S_STOP: begin
        dout_d = 1'b1;
        if (div_last) begin
          if (bit_q == STOP_LAST) begin
            // Last cycle of the final stop bit: ready again next cycle.
            state_d  = S_IDLE;
            bit_d    = '0;
            status_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        div_d    = '0;
        bit_d    = '0;
        dout_d   = 1'b1;
        status_d = 1'b1;
      end
    endcase
  end

  // State registers; reset abandons any frame and parks the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= 1'b1;
      status_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_serial_sender.sv
// Directed bench for serial_sender: four instances cover the default frame,
// even parity with two stop bits, odd parity, and BAUD_DIV = 1 back-to-back.
module tb_serial_sender;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] d_def = '0, d_even = '0, d_odd = '0, d_fast = '0;
  logic       e_def = 0,  e_even = 0,  e_odd = 0,  e_fast = 0;
  logic       o_def, o_even, o_odd, o_fast;
  logic       s_def, s_even, s_odd, s_fast;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  serial_sender #(.BAUD_DIV(5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .tx_data(d_def), .tx_en(e_def),
    .dout(o_def), .tx_status(s_def));
  serial_sender #(.BAUD_DIV(5), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(d_even), .tx_en(e_even),
    .dout(o_even), .tx_status(s_even));
  serial_sender #(.BAUD_DIV(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(d_odd), .tx_en(e_odd),
    .dout(o_odd), .tx_status(s_odd));
  serial_sender #(.BAUD_DIV(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(d_fast), .tx_en(e_fast),
    .dout(o_fast), .tx_status(s_fast));

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Start a frame, then reset it mid-flight.
    rst_n = 1'b1;
    tick();
    d_def = 8'hFF; e_def = 1'b1;
    tick();
    e_def = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_def !== 1'b1 || s_def !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: dout=%b status=%b, want 1 1", o_def, s_def);
    end
    // tx_en asserted while in reset must not be accepted.
    e_def = 1'b1;
    tick();
    vectors++;
    if (o_def !== 1'b1 || s_def !== 1'b1) begin
      errors++;
      $display("FAIL reset_vs_en: dout=%b status=%b, want 1 1", o_def, s_def);
    end
    e_def = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      vectors++;
      if (o_def !== 1'b1 || s_def !== 1'b1 || o_fast !== 1'b1 || s_fast !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle[%0d]: dout=%b status=%b, want 1 1", i, o_def, s_def);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [0:9] fr_c5;
    logic [0:9] fr_27;
    fr_c5 = 10'b0_10100011_1;
    fr_27 = 10'b0_11100100_1;
    d_def = 8'hC5; e_def = 1'b1;
    tick();
    e_def = 1'b0;
    for (int c = 0; c < 50; c++) begin
      // Ignored request with different data during the frame.
      if (c == 20) begin d_def = 8'h3C; e_def = 1'b1; end
      if (c == 21) e_def = 1'b0;
      vectors++;
      if (o_def !== fr_c5[c/5] || s_def !== 1'b0) begin
        errors++;
        $display("FAIL frame_c5[%0d]: dout=%b status=%b, want %b 0", c, o_def, s_def, fr_c5[c/5]);
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (o_def !== 1'b1 || s_def !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_c5[%0d]: dout=%b status=%b, want 1 1", i, o_def, s_def);
      end
      tick();
    end
    d_def = 8'h27; e_def = 1'b1;
    tick();
    e_def = 1'b0; d_def = 8'h00;
    for (int c = 0; c < 50; c++) begin
      vectors++;
      if (o_def !== fr_27[c/5] || s_def !== 1'b0) begin
        errors++;
        $display("FAIL frame_27[%0d]: dout=%b status=%b, want %b 0", c, o_def, s_def, fr_27[c/5]);
      end
      tick();
    end
    vectors++;
    if (o_def !== 1'b1 || s_def !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_27: dout=%b status=%b, want 1 1", o_def, s_def);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [0:9] fr_c5;
    fr_c5 = 10'b0_10100011_1;
    tick();
    d_def = 8'h27; e_def = 1'b1;
    tick();
    e_def = 1'b0;
    // Data bit 3 is frame slot 4: cycles 20..24.
    repeat (22) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_def !== 1'b1 || s_def !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset: dout=%b status=%b, want 1 1", o_def, s_def);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (o_def !== 1'b1 || s_def !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: dout=%b status=%b, want 1 1", o_def, s_def);
    end
    d_def = 8'hC5; e_def = 1'b1;
    tick();
    e_def = 1'b0;
    for (int c = 0; c < 50; c++) begin
      vectors++;
      if (o_def !== fr_c5[c/5] || s_def !== 1'b0) begin
        errors++;
        $display("FAIL fresh_frame[%0d]: dout=%b status=%b, want %b 0", c, o_def, s_def, fr_c5[c/5]);
      end
      tick();
    end
    vectors++;
    if (s_def !== 1'b1) begin
      errors++;
      $display("FAIL fresh_frame_end: status=%b, want 1", s_def);
    end
  endtask

  task automatic test_parity();
    logic [0:11] fr_even;
    logic [0:10] fr_odd;
    fr_even = 12'b0_10100011_0_11;
    fr_odd  = 11'b0_10100011_1_1;
    d_even = 8'hC5; d_odd = 8'hC5;
    e_even = 1'b1;  e_odd = 1'b1;
    tick();
    e_even = 1'b0;  e_odd = 1'b0;
    for (int c = 0; c < 60; c++) begin
      vectors++;
      if (o_even !== fr_even[c/5] || s_even !== 1'b0) begin
        errors++;
        $display("FAIL even_frame[%0d]: dout=%b status=%b, want %b 0", c, o_even, s_even, fr_even[c/5]);
      end
      vectors++;
      if (c < 55) begin
        if (o_odd !== fr_odd[c/5] || s_odd !== 1'b0) begin
          errors++;
          $display("FAIL odd_frame[%0d]: dout=%b status=%b, want %b 0", c, o_odd, s_odd, fr_odd[c/5]);
        end
      end else if (o_odd !== 1'b1 || s_odd !== 1'b1) begin
        errors++;
        $display("FAIL odd_idle[%0d]: dout=%b status=%b, want 1 1", c, o_odd, s_odd);
      end
      tick();
    end
    vectors++;
    if (o_even !== 1'b1 || s_even !== 1'b1) begin
      errors++;
      $display("FAIL even_end: dout=%b status=%b, want 1 1", o_even, s_even);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:9] fr_a5;
    logic [0:9] fr_3c;
    logic [0:9] fr;
    fr_a5 = 10'b0_10100101_1;
    fr_3c = 10'b0_00111100_1;
    d_fast = 8'hA5; e_fast = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      fr = (f == 2) ? fr_3c : fr_a5;
      for (int c = 0; c < 10; c++) begin
        // New data mid-frame only shows up in the next frame.
        if (f == 1 && c == 3) d_fast = 8'h3C;
        vectors++;
        if (o_fast !== fr[c] || s_fast !== 1'b0) begin
          errors++;
          $display("FAIL b2b_f%0d[%0d]: dout=%b status=%b, want %b 0", f, c, o_fast, s_fast, fr[c]);
        end
        tick();
      end
      if (f == 2) e_fast = 1'b0;
      vectors++;
      if (o_fast !== 1'b1 || s_fast !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap%0d: dout=%b status=%b, want 1 1", f, o_fast, s_fast);
      end
      tick();
    end
    vectors++;
    if (o_fast !== 1'b1 || s_fast !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stop: dout=%b status=%b, want 1 1", o_fast, s_fast);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_reset_mid_frame();
    test_parity();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
